// File: rtl/uart_cmd_parser.sv
// Frame parser for UART byte streams: SYNC, ADDR, D0..D3, CHK -> one addr/data command.
// Define UART_CMD_PARSER_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES between bytes.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50_000,
  parameter int unsigned ERR_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [7:0]           cmd_addr,
  output logic [31:0]          cmd_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [ERR_WIDTH-1:0] err_count
);

  typedef enum logic [2:0] {
    StHunt,
    StAddr,
    StData,
    StChk,
    StHold
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [7:0]           sum_q, sum_d;
  logic [1:0]           idx_q, idx_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic                 err_inc;
  logic                 accept;
  logic [7:0]           chk_sum;

  assign data_in_ready = (state_q != StHold);
  assign accept        = data_in_valid && data_in_ready;
  assign chk_sum       = sum_q + data_in;

  assign cmd_valid = (state_q == StHold);
  assign cmd_addr  = addr_q;
  assign cmd_data  = data_q;
  assign err_count = err_q;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_fire;
  logic            in_frame;

  assign in_frame = (state_q == StAddr) || (state_q == StData) || (state_q == StChk);
  assign tmo_fire = in_frame && !accept && (tmo_q == TmoLast);

  // Held at zero outside a frame, so entering ADDR always starts from a clean count.
  always_comb begin
    tmo_d = '0;
    if (in_frame && !accept && !tmo_fire) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic        tmo_fire;
  logic [31:0] unused_timeout_cycles;

  assign tmo_fire              = 1'b0;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    err_inc = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (accept && data_in == SYNC_BYTE) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (accept) begin
          addr_d  = data_in;
          sum_d   = data_in;
          idx_d   = 2'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          data_d[8*idx_q +: 8] = data_in;
          sum_d                = chk_sum;
          if (idx_q == 2'd3) begin
            state_d = StChk;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      StChk: begin
        if (accept) begin
          if (chk_sum == 8'h00) begin
            state_d = StHold;
          end else begin
            state_d = StHunt;
            err_inc = 1'b1;
          end
        end
      end
      StHold: begin
        if (cmd_ready) begin
          state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase

    if (tmo_fire) begin
      state_d = StHunt;
      err_inc = 1'b1;
    end
  end

  // Saturating error counter; never wraps back to zero.
  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != {ERR_WIDTH{1'b1}})) begin
      err_d = err_q + ERR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StHunt;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the byte stream from the UART receive stage over a ready/valid handshake.
- Hunts for a fixed 7-byte command frame: SYNC, ADDR, D0, D1, D2, D3, CHK.
- Verifies the frame checksum, then presents one 8-bit address / 32-bit data command to downstream register logic via ready/valid.
- Counts framing errors; optionally aborts stalled frames with an inter-byte timeout.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 50_000, max clk cycles between accepted bytes inside a frame (used only with the optional feature).
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  byte from UART receive stage.
- data_in_valid  input  1  data_in holds a byte.
- data_in_ready  output  1  parser accepts a byte this cycle.
- cmd_addr  output  8  command address.
- cmd_data  output  32  command data, little-endian (D0 = bits 7:0).
- cmd_valid  output  1  command available.
- cmd_ready  input  1  downstream consumes the command.
- err_count  output  ERR_WIDTH  saturating count of checksum and timeout errors.

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Byte accept = data_in_valid && data_in_ready. Command handoff = cmd_valid && cmd_ready.
- Reset values: state HUNT, cmd_valid 0, cmd_addr 0, cmd_data 0, err_count 0, byte index 0, running sum 0, timeout counter 0.
- data_in_ready is combinational: 1 in every state except HOLD. It is 1 in the first cycle after reset deasserts.
- States (transitions only on an accepted byte unless noted):
  - HUNT: byte == SYNC_BYTE -> ADDR. Any other byte is discarded; no error counted.
  - ADDR: latch cmd_addr, sum = byte, go to DATA with index 0. A SYNC_BYTE value here is ordinary data; no resync.
  - DATA: latch byte into cmd_data[8*idx +: 8], sum = sum + byte (mod 256). idx == 3 -> CHK, otherwise idx + 1.
  - CHK:
    - (sum + byte) mod 256 == 0 -> HOLD; cmd_valid = 1 in the next cycle (1-cycle latency from CHK byte accept).
    - Otherwise -> HUNT and err_count + 1.
  - HOLD: cmd_valid = 1 and cmd_addr/cmd_data held stable. On cmd_ready -> HUNT, with cmd_valid = 0 the next cycle. No bytes accepted; the UART stage holds or drops them.
- cmd_addr/cmd_data retain their last values outside HOLD. They are only guaranteed meaningful while cmd_valid = 1.
- err_count saturates at 2^ERR_WIDTH - 1; it never wraps.
- Reset mid-frame or during HOLD: immediate return to reset values; the partial or pending command is lost.
- Every state transition completes in one cycle; there are no bubble cycles between accepted bytes.

Optional Feature:
- Macro: UART_CMD_PARSER_TIMEOUT_EN.
- Defined:
  - A counter runs in ADDR/DATA/CHK and clears on every accepted byte and on entering ADDR.
  - When the counter reaches TIMEOUT_CYCLES - 1 with no byte accepted that cycle: -> HUNT, err_count + 1 (saturating).
  - A byte accepted in the same cycle wins; no timeout occurs.
  - The counter is idle in HUNT and HOLD.
- Undefined: no timeout logic; the parser waits indefinitely mid-frame.

Test Plan:
- Good frame: send A5 10 78 56 34 12 DC -> cmd_valid rises 1 cycle after DC is accepted; cmd_addr = 0x10, cmd_data = 0x12345678, err_count = 0.
- Bad checksum: send A5 10 78 56 34 12 DD -> no cmd_valid, err_count = 1. Then send the good frame -> parsed correctly.
- Noise and in-frame sync value:
  - Send 00 FF 5A, then A5 A5 00 00 00 00 5B -> one command, cmd_addr = 0xA5, cmd_data = 0, err_count = 0.
- Backpressure: hold cmd_ready = 0 for 20 cycles after a good frame -> data_in_ready = 0 and outputs stable throughout. Assert cmd_ready -> one handoff, then the next frame is accepted.
- Timeout (macro defined): send A5 10, idle TIMEOUT_CYCLES cycles -> back in HUNT, err_count = 1. Then a full good frame parses. Macro undefined: after the idle period, sending 78 56 34 12 DC completes the command.
- Saturation and reset: send 300 bad-checksum frames -> err_count = 255. Assert reset after A5 10 78 -> err_count = 0, cmd_valid = 0, and the next good frame parses.
